ram_fifo_stream_reader: RTL and testbench

//  Read-side drain engine for the dual-port Block-RAM FIFO. Pops the FIFO's first-word-fall-through read port
//  (rden/rddata/empty) and presents beats on a registered valid/ready master stream, tagging every PKT_LEN-th beat as last.
//  The 2-entry output buffer gives full throughput. It has no combinational path from i_m_ready to o_fifo_rden or to any output.

---
 rtl/ram_fifo_pkg.sv | 16 +
 rtl/ram_fifo_stream_reader_skid_buf.sv | 76 +++++++
 rtl/ram_fifo_stream_reader.sv | 59 +++++
 tb/tb_ram_fifo_stream_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared types and helpers for the Block-RAM FIFO read-side stream logic.
package ram_fifo_pkg;

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    function automatic int unsigned pkt_cnt_w(input int unsigned pkt_len);
        int unsigned w;
        w = $clog2(pkt_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ram_fifo_stream_reader_skid_buf.sv
// Two-entry head/skid output buffer: head register drives the stream, skid catches
// the one extra beat that can arrive while the consumer is stalled.
module stream_skid_buf
    import ram_fifo_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         flush,
    output logic         valid,
    output logic [W-1:0] data,
    input  logic         ready,
    output logic [1:0]   occ
);

    occ_t         occ_rg, occ_nxt;
    logic [W-1:0] h_rg, h_nxt;
    logic [W-1:0] s_rg, s_nxt;
    logic         acc;

    assign valid = (occ_rg != OCC_0);
    assign data  = h_rg;
    assign occ   = occ_rg;
    assign acc   = valid & ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ_rg <= OCC_0;
            h_rg   <= '0;
            s_rg   <= '0;
        end else begin
            occ_rg <= occ_nxt;
            h_rg   <= h_nxt;
            s_rg   <= s_nxt;
        end
    end

    always_comb begin
        occ_nxt = occ_rg;
        h_nxt   = h_rg;
        s_nxt   = s_rg;
        case (occ_rg)
            OCC_0: begin
                if (push) begin
                    h_nxt   = push_data;
                    occ_nxt = OCC_1;
                end
            end
            OCC_1: begin
                if (push && !acc) begin
                    s_nxt   = push_data;
                    occ_nxt = OCC_2;
                end else if (push && acc) begin
                    h_nxt = push_data;
                end else if (acc) begin
                    occ_nxt = OCC_0;
                end
            end
            OCC_2: begin
                if (acc) begin
                    h_nxt   = s_rg;
                    occ_nxt = OCC_1;
                end
            end
            default: occ_nxt = OCC_0;
        endcase
        // Flush empties the buffer but leaves head data in place; valid qualifies it.
        if (flush) begin
            occ_nxt = OCC_0;
        end
    end

endmodule

// File: rtl/ram_fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO onto a registered valid/ready stream,
// marking every PKT_LEN-th beat as last.
module ram_fifo_stream_reader
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PKT_LEN = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_en,
    input  logic              i_flush,
    output logic              o_fifo_rden,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    input  logic              i_fifo_empty,
    output logic              o_m_valid,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_last,
    input  logic              i_m_ready,
    output logic [1:0]        o_occ
);

    localparam int unsigned     CW       = pkt_cnt_w(PKT_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(PKT_LEN - 1);

    logic [CW-1:0] pkt_cnt_rg;
    logic          last_tag;
    logic [DATA_W:0] buf_data;

    // Pop decision uses only registered occupancy, so ready never reaches rden.
    assign o_fifo_rden = rstn & i_en & ~i_flush & ~i_fifo_empty & (o_occ < 2'd2);
    assign last_tag    = (pkt_cnt_rg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            pkt_cnt_rg <= '0;
        end else if (o_fifo_rden) begin
            pkt_cnt_rg <= last_tag ? '0 : pkt_cnt_rg + CW'(1);
        end
    end

    stream_skid_buf #(
        .W(DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (o_fifo_rden),
        .push_data ({i_fifo_rddata, last_tag}),
        .flush     (i_flush),
        .valid     (o_m_valid),
        .data      (buf_data),
        .ready     (i_m_ready),
        .occ       (o_occ)
    );

    assign o_m_data = buf_data[DATA_W:1];
    assign o_m_last = buf_data[0];

endmodule

// File: tb/tb_ram_fifo_stream_reader.sv
// Scoreboard bench: a behavioural FIFO feeds the reader; expected beats are queued on pop and
// checked by a negedge monitor whenever the stream presents data.
module tb_ram_fifo_stream_reader;

    localparam int PKT_LEN = 4;
    localparam int DEPTH   = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rstn, en, flush, ready;
    logic       fifo_empty;
    logic [7:0] fifo_rddata;
    logic       o_fifo_rden, o_m_valid, o_m_last;
    logic [7:0] o_m_data;
    logic [1:0] o_occ;

    logic [7:0] fifo_q[$];
    beat_t      exp_q[$];
    int         pkt_idx     = 0;
    int         acc_total   = 0;
    int         pops        = 0;
    int         checks      = 0;
    int         failures    = 0;
    bit         started     = 0;
    bit         rst_applied = 1;

    ram_fifo_stream_reader #(.DATA_W(8), .PKT_LEN(PKT_LEN)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_en          (en),
        .i_flush       (flush),
        .o_fifo_rden   (o_fifo_rden),
        .i_fifo_rddata (fifo_rddata),
        .i_fifo_empty  (fifo_empty),
        .o_m_valid     (o_m_valid),
        .o_m_data      (o_m_data),
        .o_m_last      (o_m_last),
        .i_m_ready     (ready),
        .o_occ         (o_occ)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        fifo_empty  = (fifo_q.size() == 0);
        fifo_rddata = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        settle();
    endtask

    task automatic fifo_write(input logic [7:0] v);
        if (fifo_q.size() < DEPTH) fifo_q.push_back(v);
        settle();
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    // Monitor: occupancy equals beats popped but not yet accepted.
    always @(negedge clk) begin
        int   sz;
        logic exp_rden;
        if (started) begin
            sz       = exp_q.size();
            exp_rden = rstn & en & ~flush & ~fifo_empty & (sz < 2);
            chk("rden", 32'(o_fifo_rden), 32'(exp_rden));
            chk("occ", 32'(o_occ), 32'(sz));
            chk("valid", 32'(o_m_valid), 32'(sz != 0));
            if (rst_applied) begin
                chk("rst_data", 32'(o_m_data), 32'd0);
                chk("rst_last", 32'(o_m_last), 32'd0);
            end else if (o_m_valid && sz > 0) begin
                chk("data", 32'(o_m_data), 32'(exp_q[0].d));
                chk("last", 32'(o_m_last), 32'(exp_q[0].l));
            end
            if (o_m_valid && ready && sz > 0) begin
                void'(exp_q.pop_front());
                acc_total++;
            end
            if (o_fifo_rden) begin
                chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) begin
                    exp_q.push_back('{d: fifo_q[0], l: (pkt_idx == PKT_LEN - 1)});
                    pkt_idx = (pkt_idx + 1) % PKT_LEN;
                    void'(fifo_q.pop_front());
                    pops++;
                end
            end
            if (!rstn || flush) begin
                exp_q.delete();
                pkt_idx = 0;
            end
            rst_applied = !rstn;
        end
    end

    initial begin
        int base;
        int written;
        bit ok;
        rstn = 1'b0; en = 1'b1; flush = 1'b0; ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_write(8'(i));
        settle();

        // Reset with a full FIFO
        tick();
        started = 1;
        tick(); tick();

        // Full-rate stream of 01..08
        rstn = 1'b1;
        base = acc_total;
        repeat (9) tick();
        chk("stream_count", 32'(acc_total - base), 32'd8);
        drain();

        // Backpressure
        ready = 1'b0;
        base  = pops;
        for (int i = 1; i <= 8; i++) fifo_write(8'(i));
        repeat (5) tick();
        chk("bp_pops", 32'(pops - base), 32'd2);
        chk("bp_occ", 32'(o_occ), 32'd2);
        chk("bp_data", 32'(o_m_data), 32'h01);
        ready = 1'b1;
        tick();
        chk("bp_occ_after", 32'(o_occ), 32'd1);
        drain();

        // Random traffic
        written = 0;
        base    = acc_total;
        ok      = 0;
        for (int c = 0; c < 3000; c++) begin
            if (written >= 64 && fifo_q.size() == 0 && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            ready = 1'($urandom_range(0, 1));
            if (written < 64 && fifo_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                fifo_write(8'($urandom));
                written++;
            end
            tick();
        end
        chk("rand_done", 32'(ok), 32'd1);
        chk("rand_beats", 32'(acc_total - base), 32'd64);

        // Flush with two beats buffered
        ready = 1'b0;
        for (int i = 1; i <= 6; i++) fifo_write(8'(i));
        repeat (3) tick();
        chk("fl_occ_pre", 32'(o_occ), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(o_m_valid), 32'd0);
        chk("fl_occ", 32'(o_occ), 32'd0);
        ready = 1'b1;
        base  = acc_total;
        drain();
        chk("fl_beats", 32'(acc_total - base), 32'd4);

        // Reset mid-packet
        base = acc_total;
        for (int i = 1; i <= 4; i++) fifo_write(8'(i));
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (acc_total - base >= 2) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("mr_wait", 32'(ok), 32'd1);
        rstn  = 1'b0;
        ready = 1'b0;
        fifo_q.delete();
        settle();
        tick(); tick();
        rstn  = 1'b1;
        ready = 1'b1;
        base  = acc_total;
        for (int i = 16; i <= 19; i++) fifo_write(8'(i));
        drain();
        chk("mr_beats", 32'(acc_total - base), 32'd4);

        // Enable gating
        ready = 1'b0;
        for (int i = 32; i <= 37; i++) fifo_write(8'(i));
        repeat (3) tick();
        en    = 1'b0;
        ready = 1'b1;
        base  = pops;
        repeat (4) tick();
        chk("en_occ", 32'(o_occ), 32'd0);
        chk("en_fifo_left", 32'(fifo_q.size()), 32'd4);
        chk("en_pops", 32'(pops - base), 32'd0);
        en = 1'b1;
        drain();

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
